hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates operand forwarding selects for the EX-stage ALU/br_cond muxes.
- Generates stall and flush (bubble) controls for the stage buffers: load-use stalls, EX-resolved branch/jump flushes, mret/epc redirect flushes.
- Sequences the timer interrupt: drains in-flight instructions, then issues a one-cycle trap-take to csr_reg.

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: EX forwarding selects, load-use stalls, redirect flushes, timer-interrupt drain/trap.
// Optional `define HAZARD_PERF_EN adds free-running stall_cnt / flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rs1_ex,
  input  logic [4:0]  rs2_ex,
  input  logic [4:0]  rd_ex,
  input  logic        rf_en_ex,
  input  logic        rd_en_ex,
  input  logic [4:0]  rd_mem,
  input  logic        rf_en_mem,
  input  logic [4:0]  rd_wb,
  input  logic        rf_en_wb,
  input  logic        br_take_ex,
  input  logic        epc_taken_mem,
  input  logic        timer_interrupt,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic        irq_take
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, TRAP} state_t;

  localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LAT - 1);
  localparam logic [2:0] DRAIN_CNT = 3'(DRAIN_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       irq_pend_q, ti_q, irq_rise, load_use;
  logic       stall_if_c, stall_id_c, flush_id_c, flush_ex_c, flush_mem_c, irq_take_c;

  // Youngest producer wins: MEM result is newer than WB data.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_en,
                                         input logic [4:0] mem_rd, input logic wb_en,
                                         input logic [4:0] wb_rd);
    if (mem_en && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs)     return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a_sel = rst ? 2'b00 : fwd_sel(rs1_ex, rf_en_mem, rd_mem, rf_en_wb, rd_wb);
  assign fwd_b_sel = rst ? 2'b00 : fwd_sel(rs2_ex, rf_en_mem, rd_mem, rf_en_wb, rd_wb);

  assign load_use = rd_en_ex & rf_en_ex & (rd_ex != 5'd0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
  assign irq_rise = timer_interrupt & ~ti_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    flush_mem_c = 1'b0;
    irq_take_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (epc_taken_mem) begin
          {flush_id_c, flush_ex_c, flush_mem_c} = 3'b111;
        end else if (br_take_ex) begin
          {flush_id_c, flush_ex_c} = 2'b11;
        end else if (load_use) begin
          {stall_if_c, stall_id_c, flush_ex_c} = 3'b111;
          cnt_d = LOAD_CNT;
          if (LOAD_LAT > 1) state_d = STALL;
        end else if (irq_pend_q) begin
          {stall_if_c, flush_id_c} = 2'b11;
          cnt_d   = DRAIN_CNT;
          state_d = (DRAIN_CYC > 1) ? DRAIN : TRAP;
        end
      end
      // cnt holds the stall/drain cycles still owed, including the current one.
      STALL: begin
        if (epc_taken_mem) begin
          {flush_id_c, flush_ex_c, flush_mem_c} = 3'b111;
          state_d = RUN;
        end else if (br_take_ex) begin
          {flush_id_c, flush_ex_c} = 2'b11;
          state_d = RUN;
        end else if (cnt_q != 3'd0) begin
          {stall_if_c, stall_id_c, flush_ex_c} = 3'b111;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (epc_taken_mem) begin
          {flush_id_c, flush_ex_c, flush_mem_c} = 3'b111;
          state_d = RUN;
        end else begin
          {stall_if_c, flush_id_c} = 2'b11;
          flush_ex_c = br_take_ex;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = TRAP;
        end
      end
      TRAP: begin
        irq_take_c = 1'b1;
        stall_if_c = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_if  = stall_if_c  & ~rst;
  assign stall_id  = stall_id_c  & ~rst;
  assign flush_id  = flush_id_c  & ~rst;
  assign flush_ex  = flush_ex_c  & ~rst;
  assign flush_mem = flush_mem_c & ~rst;
  assign irq_take  = irq_take_c  & ~rst;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      irq_pend_q <= 1'b0;
      ti_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ti_q       <= timer_interrupt;
      // A new edge in the clearing cycle re-arms the request.
      irq_pend_q <= irq_rise | (irq_pend_q & ~irq_take_c);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_id) stall_cnt <= stall_cnt + 32'd1;
      if (flush_id | flush_ex | flush_mem) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
// Control vectors are packed as {stall_if, stall_id, flush_id, flush_ex, flush_mem, irq_take}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic       rs1_used_id, rs2_used_id, rf_en_ex, rd_en_ex, rf_en_mem, rf_en_wb;
  logic       br_take_ex, epc_taken_mem, timer_interrupt;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic       si1, sd1, fi1, fe1, fm1, it1;
  logic       si3, sd3, fi3, fe3, fm3, it3;
`ifdef HAZARD_PERF_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .DRAIN_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rf_en_ex(rf_en_ex), .rd_en_ex(rd_en_ex), .rd_mem(rd_mem), .rf_en_mem(rf_en_mem),
    .rd_wb(rd_wb), .rf_en_wb(rf_en_wb), .br_take_ex(br_take_ex), .epc_taken_mem(epc_taken_mem),
    .timer_interrupt(timer_interrupt), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_if(si1),
    .stall_id(sd1), .flush_id(fi1), .flush_ex(fe1), .flush_mem(fm1), .irq_take(it1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .DRAIN_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rf_en_ex(rf_en_ex), .rd_en_ex(rd_en_ex), .rd_mem(rd_mem), .rf_en_mem(rf_en_mem),
    .rd_wb(rd_wb), .rf_en_wb(rf_en_wb), .br_take_ex(br_take_ex), .epc_taken_mem(epc_taken_mem),
    .timer_interrupt(timer_interrupt), .fwd_a_sel(fa3), .fwd_b_sel(fb3), .stall_if(si3),
    .stall_id(sd3), .flush_id(fi3), .flush_ex(fe3), .flush_mem(fm3), .irq_take(it3)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  wire [5:0] ctl1 = {si1, sd1, fi1, fe1, fm1, it1};
  wire [5:0] ctl3 = {si3, sd3, fi3, fe3, fm3, it3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {rs1_used_id, rs2_used_id, rf_en_ex, rd_en_ex, rf_en_mem, rf_en_wb} = '0;
    {br_take_ex, epc_taken_mem} = '0;
  endtask

  task automatic set_load_use();
    rd_en_ex = 1'b1; rf_en_ex = 1'b1; rd_ex = 5'd3; rs2_id = 5'd3; rs2_used_id = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    timer_interrupt = 1'b0;
    clear_inputs();
    // Outputs stay quiet under reset even with hazards on the inputs.
    rf_en_mem = 1'b1; rd_mem = 5'd5; rs1_ex = 5'd5; br_take_ex = 1'b1;
    tick(); tick();
    #1;
    check("rst_fwd_a", 32'(fa1), 32'h0);
    check("rst_ctl", 32'(ctl1), 32'h00);
    rst = 1'b0;
    clear_inputs();
    tick();
    #1;
    check("idle_ctl", 32'(ctl3), 32'h00);

    // Forwarding
    rd_mem = 5'd5; rd_wb = 5'd5; rf_en_mem = 1'b1; rf_en_wb = 1'b1; rs1_ex = 5'd5;
    #1;
    check("fwd_a_mem", 32'(fa1), 32'h1);
    check("fwd_b_none", 32'(fb1), 32'h0);
    rd_mem = 5'd0;
    #1;
    check("fwd_a_wb", 32'(fa1), 32'h2);
    rd_mem = 5'd5; rf_en_mem = 1'b0; rs2_ex = 5'd5;
    #1;
    check("fwd_b_wb", 32'(fb3), 32'h2);
    rs1_ex = 5'd0; rd_wb = 5'd0; rs2_ex = 5'd0;
    #1;
    check("fwd_x0", 32'(fa1), 32'h0);
    clear_inputs();

    // Load-use: 1 cycle for LOAD_LAT=1, 3 for LOAD_LAT=3
    set_load_use();
    rs2_used_id = 1'b0;
    #1;
    check("lu_unused", 32'(ctl1), 32'h00);
    rs2_used_id = 1'b1;
    #1;
    check("lu1_c0", 32'(ctl1), 32'h34);
    check("lu3_c0", 32'(ctl3), 32'h34);
    tick();
    clear_inputs();
    #1;
    check("lu1_c1", 32'(ctl1), 32'h00);
    check("lu3_c1", 32'(ctl3), 32'h34);
    tick();
    #1;
    check("lu3_c2", 32'(ctl3), 32'h34);
    tick();
    #1;
    check("lu3_c3", 32'(ctl3), 32'h00);

    // Branch beats a simultaneous load-use
    set_load_use();
    br_take_ex = 1'b1;
    #1;
    check("br_lu", 32'(ctl3), 32'h0C);
    tick();
    clear_inputs();
    #1;
    check("br_lu_after", 32'(ctl3), 32'h00);

    // Reset in the second STALL cycle abandons the sequence
    set_load_use();
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_stall_now", 32'(ctl3), 32'h00);
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall_next", 32'(ctl3), 32'h00);
`ifdef HAZARD_PERF_EN
    check("perf_stall0", sc3, 32'h0);
    check("perf_flush0", fc3, 32'h0);
`endif
    tick();
    #1;
    check("rst_stall_idle", 32'(ctl3), 32'h00);

    // Timer interrupt: 3 drain cycles then one trap strobe
    timer_interrupt = 1'b1;
    #1;
    check("irq_req", 32'(ctl1), 32'h00);
    tick();
    #1;
    check("irq_d1", 32'(ctl1), 32'h28);
    tick();
    #1;
    check("irq_d2", 32'(ctl1), 32'h28);
    tick();
    #1;
    check("irq_d3", 32'(ctl3), 32'h28);
    tick();
    #1;
    check("irq_trap", 32'(ctl1), 32'h21);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("irq_level_held", 32'(ctl1), 32'h00);
    end

    // epc redirect during DRAIN, then a fresh drain (with a branch in it) and the trap
    timer_interrupt = 1'b0;
    tick();
    timer_interrupt = 1'b1;
    tick();
    #1;
    check("epc_d1", 32'(ctl1), 32'h28);
    tick();
    epc_taken_mem = 1'b1;
    #1;
    check("epc_in_drain", 32'(ctl1), 32'h0E);
    tick();
    epc_taken_mem = 1'b0;
    #1;
    check("redrain_d1", 32'(ctl1), 32'h28);
    tick();
    br_take_ex = 1'b1;
    #1;
    check("redrain_d2_br", 32'(ctl1), 32'h2C);
    tick();
    br_take_ex = 1'b0;
    #1;
    check("redrain_d3", 32'(ctl1), 32'h28);
    tick();
    #1;
    check("redrain_trap", 32'(ctl1), 32'h21);
    tick();
    #1;
    check("redrain_done", 32'(ctl1), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
